count_down_bcd: RTL and testbench

//  Synchronous presettable down-counter/timer; the count-down counterpart of the team's 74LS163 up-counter.

---
 rtl/count_pkg.sv | 15 +
 rtl/count_digit_dec.sv | 27 ++
 rtl/count_down_bcd.sv | 120 ++++++++++++
 tb/tb_count_down_bcd.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared types and constants for the presettable BCD/binary down-counter.
package count_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] HEX_MAX = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/count_digit_dec.sv
// One 4-bit digit of the down-counter: decrements when a borrow arrives and
// passes a borrow on when it wraps from zero.
module count_digit_dec
    import count_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    input  logic               bin,
    input  logic               bcd,
    output logic [DIGIT_W-1:0] d_next,
    output logic               bout
);

    // NOTE: every output is given a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        d_next = d;
        bout   = 1'b0;
        if (bin) begin
            if (d == '0) begin
                d_next = bcd ? BCD_MAX : HEX_MAX;
                bout   = 1'b1;
            end else begin
                d_next = d - 4'd1;
            end
        end
    end

endmodule

// File: rtl/count_down_bcd.sv
// Presettable down-counter/timer with prescaler, pause, cascade enable,
// registered borrow pulse and optional auto-reload.
module count_down_bcd
    import count_pkg::*;
#(
    parameter int unsigned DIGITS      = 2,
    parameter bit          BCD         = 1'b1,
    parameter logic [25:0] TICK_DIV    = 26'd50000000,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic                        clk_50M,
    input  logic                        rst_n,
    input  logic                        LD,
    input  logic [DIGITS*DIGIT_W-1:0]   D,
    input  logic                        start,
    input  logic                        pause,
    input  logic                        ct_en,
    output logic [DIGITS*DIGIT_W-1:0]   Q,
    output logic                        bo,
    output logic                        done
);

    localparam int W = DIGITS * DIGIT_W;

    state_e         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic [25:0]    cnt_q, cnt_d;
    logic           bo_q, bo_d;
    logic           done_q;

    logic           tick;
    logic           q_zero;
    logic [W-1:0]   q_dec;
    logic [DIGITS:0] borrow;

    assign tick = (cnt_q == TICK_DIV - 26'd1);

    // Free-running prescaler, realigned by a load or a start.
    always_comb begin
        cnt_d = cnt_q + 26'd1;
        if (!LD || start || tick) begin
            cnt_d = '0;
        end
    end

    assign borrow[0] = 1'b1;
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        count_digit_dec u_digit (
            .d      (q_q[g*DIGIT_W +: DIGIT_W]),
            .bin    (borrow[g]),
            .bcd    (BCD),
            .d_next (q_dec[g*DIGIT_W +: DIGIT_W]),
            .bout   (borrow[g+1])
        );
    end

    // A borrow ripples out of the MSD only when every digit is zero.
    assign q_zero = borrow[DIGITS];

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        bo_d    = 1'b0;
        if (!LD) begin
            state_d = ST_IDLE;
            q_d     = D;
        end else if (start) begin
            if (state_q == ST_IDLE || state_q == ST_DONE) begin
                state_d = ST_RUN;
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick && ct_en) begin
                        if (!q_zero) begin
                            q_d = q_dec;
                        end else begin
                            bo_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                q_d = D;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            bo_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            bo_q    <= bo_d;
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign Q    = q_q;
    assign bo   = bo_q;
    assign done = done_q;

endmodule

// File: tb/tb_count_down_bcd.sv
// Bench for count_down_bcd: three configurations share one stimulus stream
// and are checked each cycle against a behavioural timer model.
module tb_count_down_bcd;

    localparam int TDIV = 2;
    localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2, S_DONE = 3;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic       LD;
    logic [7:0] D;
    logic       start;
    logic       pause;
    logic       ct_en;
    logic [7:0] q_o    [3];
    logic       bo_o   [3];
    logic       done_o [3];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_q    [3];
    bit         m_bo   [3];
    bit         m_done [3];
    int         m_st   [3];
    int         m_cnt;

    always #5 clk_50M = ~clk_50M;

    count_down_bcd #(.DIGITS(2), .BCD(1'b1), .TICK_DIV(26'd2), .AUTO_RELOAD(1'b0)) dut_bcd (
        .clk_50M(clk_50M), .rst_n(rst_n), .LD(LD), .D(D), .start(start), .pause(pause),
        .ct_en(ct_en), .Q(q_o[0]), .bo(bo_o[0]), .done(done_o[0]));

    count_down_bcd #(.DIGITS(2), .BCD(1'b0), .TICK_DIV(26'd2), .AUTO_RELOAD(1'b0)) dut_bin (
        .clk_50M(clk_50M), .rst_n(rst_n), .LD(LD), .D(D), .start(start), .pause(pause),
        .ct_en(ct_en), .Q(q_o[1]), .bo(bo_o[1]), .done(done_o[1]));

    count_down_bcd #(.DIGITS(2), .BCD(1'b1), .TICK_DIV(26'd2), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk_50M(clk_50M), .rst_n(rst_n), .LD(LD), .D(D), .start(start), .pause(pause),
        .ct_en(ct_en), .Q(q_o[2]), .bo(bo_o[2]), .done(done_o[2]));

    function automatic bit cfg_bcd(input int i);
        return i != 1;
    endfunction

    function automatic bit cfg_ar(input int i);
        return i == 2;
    endfunction

    // Count one down; only called with v != 0.
    function automatic logic [7:0] m_dec(input logic [7:0] v, input bit bcd);
        logic [3:0] hi;
        if (!bcd || v[3:0] != 4'd0) return v - 8'd1;
        hi = v[7:4] - 4'd1;
        return {hi, 4'd9};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_q%0d", tag, i), {24'd0, q_o[i]}, {24'd0, m_q[i]});
            check($sformatf("%s_bo%0d", tag, i), {31'd0, bo_o[i]}, {31'd0, m_bo[i]});
            check($sformatf("%s_done%0d", tag, i), {31'd0, done_o[i]}, {31'd0, m_done[i]});
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            m_q[i] = 8'h00; m_bo[i] = 1'b0; m_done[i] = 1'b0; m_st[i] = S_IDLE;
        end
    endtask

    task automatic model_update();
        bit tick;
        tick = (m_cnt == TDIV - 1);
        if (!LD || start || tick) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        for (int i = 0; i < 3; i++) begin
            m_bo[i] = 1'b0;
            if (!LD) begin
                m_q[i] = D; m_st[i] = S_IDLE;
            end else if (start) begin
                if (m_st[i] == S_IDLE || m_st[i] == S_DONE) m_st[i] = S_RUN;
            end else if (m_st[i] == S_RUN && pause) begin
                m_st[i] = S_HOLD;
            end else if (m_st[i] == S_HOLD && !pause) begin
                m_st[i] = S_RUN;
            end else if (m_st[i] == S_RUN && tick && ct_en) begin
                if (m_q[i] != 8'h00) begin
                    m_q[i] = m_dec(m_q[i], cfg_bcd(i));
                end else begin
                    m_bo[i] = 1'b1;
                    if (cfg_ar(i)) m_q[i] = D;
                    else m_st[i] = S_DONE;
                end
            end
            m_done[i] = (m_st[i] == S_DONE);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk_50M);
        model_update();
        @(negedge clk_50M);
        check_all(tag);
    endtask

    task automatic load_and_start(input logic [7:0] val, input string tag);
        LD = 1'b0; D = val;
        step({tag, "_ld"});
        LD = 1'b1; start = 1'b1;
        step({tag, "_st"});
        start = 1'b0;
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    // Bounded wait for the BCD instance to show a given count.
    task automatic run_until_q(input logic [7:0] val, input string tag);
        for (int k = 0; k < 60 && q_o[0] !== val; k++) step(tag);
        check({tag, "_reach"}, {24'd0, q_o[0]}, {24'd0, val});
    endtask

    initial begin
        rst_n = 1'b0; LD = 1'b1; D = 8'h00; start = 1'b0; pause = 1'b0; ct_en = 1'b1;
        model_reset();
        #1 check_all("reset");
        @(negedge clk_50M);
        rst_n = 1'b1;
        run(2, "idle");

        // Asynchronous reset while counting
        load_and_start(8'h09, "t1");
        run_until_q(8'h07, "t1_run");
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("t1_async");
        @(negedge clk_50M);
        rst_n = 1'b1;
        run(2, "t1_idle");
        start = 1'b1;
        step("t1_restart");
        start = 1'b0;
        run(4, "t1_zero_run");

        // Full BCD countdown to DONE, then rerun from DONE without reload
        load_and_start(8'h12, "t2");
        run(2 * 13 + 4, "t2_run");
        check("t2_done_bcd", {31'd0, done_o[0]}, 32'd1);
        check("t2_hold_q", {24'd0, q_o[0]}, 32'h00);
        start = 1'b1;
        step("t2_rerun");
        start = 1'b0;
        run(4, "t2_rerun_run");

        // Borrow across digits in binary mode
        load_and_start(8'h10, "t3");
        run(6, "t3_run");

        // Auto-reload divider
        load_and_start(8'h03, "t4");
        run(20, "t4_run");

        // Pause, then cascade-enable freeze
        load_and_start(8'h07, "t5");
        run_until_q(8'h05, "t5_pre");
        pause = 1'b1;
        run(6, "t5_pause");
        check("t5_pause_hold", {24'd0, q_o[0]}, 32'h05);
        pause = 1'b0;
        run(6, "t5_resume");
        load_and_start(8'h02, "t5b");
        ct_en = 1'b0;
        run(10, "t5_cten_off");
        check("t5_cten_hold", {24'd0, q_o[0]}, 32'h02);
        ct_en = 1'b1;
        run(8, "t5_cten_on");

        // Load beats start, and load beats a terminal tick
        load_and_start(8'h08, "t6");
        run_until_q(8'h04, "t6_pre");
        LD = 1'b0; start = 1'b1; D = 8'h25;
        step("t6_ld_start");
        LD = 1'b1; start = 1'b0;
        run(4, "t6_idle");
        check("t6_idle_q", {24'd0, q_o[0]}, 32'h25);
        load_and_start(8'h00, "t6b");
        for (int k = 0; k < 4 && m_cnt != TDIV - 1; k++) step("t6b_align");
        LD = 1'b0; D = 8'h33;
        step("t6b_ld_term");
        check("t6b_bo_low", {31'd0, bo_o[0]}, 32'd0);
        LD = 1'b1;
        run(2, "t6b_after");

        // Randomised traffic
        for (int k = 0; k < 500; k++) begin
            LD    = ($urandom % 25) != 0;
            D     = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            start = ($urandom % 15) == 0;
            if ($urandom % 6 == 0) pause = ~pause;
            ct_en = ($urandom % 7) != 0;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
